// File: rtl/countdown_timer_nbit_if.sv
// Load handshake for countdown_timer_nbit: a start value moves when loadValid && loadReady.
// The master drives loadValid and loadValue, and the timer answers with loadReady.
interface countdown_timer_nbit_if #(
  parameter int WIDTH = 10
);
  logic             loadValid;
  logic [WIDTH-1:0] loadValue;
  logic             loadReady;

  modport master (output loadValid, output loadValue, input loadReady);
  modport slave  (input loadValid, input loadValue, output loadReady);
endinterface

// File: rtl/countdown_timer_nbit.sv
// Loadable down-counter with terminal-count pulse; it either stops in DONE or auto-reloads
// the captured start value to make a periodic tick.
module countdown_timer_nbit #(
  parameter int WIDTH     = 10,
  parameter int DECREMENT = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  countdown_timer_nbit_if.slave lb,
  input  logic                 enable,
  input  logic                 autoReload,
  input  logic                 abort,
  output logic [WIDTH-1:0]     countValue,
  output logic                 busy,
  output logic                 done,
  output logic                 terminal,
  output logic [1:0]           debugState
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] DEC = WIDTH'(DECREMENT);

  state_t           state, state_next;
  logic [WIDTH-1:0] reloadReg, reload_next;
  logic [WIDTH-1:0] count_next;
  logic             terminal_next;
  logic             load_take;

  assign lb.loadReady = ((state == IDLE) || (state == DONE)) && !reset;
  assign busy         = (state == RUNNING);
  assign done         = (state == DONE);
  assign debugState   = state;

  // In DONE an abort beats a simultaneous load, even though loadReady is high.
  assign load_take = lb.loadValid && lb.loadReady && !((state == DONE) && abort);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      countValue <= '0;
      reloadReg  <= '0;
      terminal   <= 1'b0;
    end else begin
      state      <= state_next;
      countValue <= count_next;
      reloadReg  <= reload_next;
      terminal   <= terminal_next;
    end
  end

  always_comb begin
    state_next    = state;
    count_next    = countValue;
    reload_next   = reloadReg;
    terminal_next = 1'b0;
    case (state)
      IDLE, DONE: begin
        count_next = '0;
        if ((state == DONE) && abort) begin
          state_next = IDLE;
        end else if (load_take) begin
          reload_next = lb.loadValue;
          if (lb.loadValue != '0) begin
            count_next = lb.loadValue;
            state_next = RUNNING;
          end else begin
            terminal_next = 1'b1;
            state_next    = DONE;
          end
        end
      end
      RUNNING: begin
        if (abort) begin
          count_next = '0;
          state_next = IDLE;
        end else if (enable) begin
          // Compare before subtracting so a count below DEC saturates instead of wrapping.
          if (countValue <= DEC) begin
            terminal_next = 1'b1;
            if (autoReload) begin
              count_next = reloadReg;
            end else begin
              count_next = '0;
              state_next = DONE;
            end
          end else begin
            count_next = countValue - DEC;
          end
        end
      end
      default: begin
        count_next = '0;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_countdown_timer_nbit.sv
// Bench for countdown_timer_nbit: two instances (10-bit step 1, 4-bit step 3) checked every
// cycle against a behavioural model of the timer.
module tb_countdown_timer_nbit;
  localparam int WA = 10;
  localparam int DA = 1;
  localparam int WB = 4;
  localparam int DB = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst_a, en_a, ar_a, ab_a;
  logic rst_b, en_b, ar_b, ab_b;
  logic [WA-1:0] cnt_a;
  logic [WB-1:0] cnt_b;
  logic busy_a, done_a, term_a, busy_b, done_b, term_b;
  logic [1:0] st_a, st_b;

  countdown_timer_nbit_if #(.WIDTH(WA)) lif_a ();
  countdown_timer_nbit_if #(.WIDTH(WB)) lif_b ();

  countdown_timer_nbit #(.WIDTH(WA), .DECREMENT(DA)) dut_a (
    .clock(clock), .reset(rst_a), .lb(lif_a.slave), .enable(en_a), .autoReload(ar_a),
    .abort(ab_a), .countValue(cnt_a), .busy(busy_a), .done(done_a), .terminal(term_a),
    .debugState(st_a)
  );

  countdown_timer_nbit #(.WIDTH(WB), .DECREMENT(DB)) dut_b (
    .clock(clock), .reset(rst_b), .lb(lif_b.slave), .enable(en_b), .autoReload(ar_b),
    .abort(ab_b), .countValue(cnt_b), .busy(busy_b), .done(done_b), .terminal(term_b),
    .debugState(st_b)
  );

  typedef struct {
    int cnt;
    int reload;
    bit busy;
    bit done;
    bit term;
  } mdl_t;

  mdl_t ma, mb;
  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: remaining count plus running/finished flags, stepped once per edge.
  function automatic mdl_t mdl_step(mdl_t m, bit rst, bit lv, int lval, bit en, bit ar,
                                    bit ab, int dec);
    mdl_t n;
    n = m;
    n.term = 1'b0;
    if (rst) begin
      n.cnt = 0; n.reload = 0; n.busy = 1'b0; n.done = 1'b0;
    end else if (m.busy) begin
      if (ab) begin
        n.busy = 1'b0; n.cnt = 0;
      end else if (en) begin
        if (m.cnt - dec <= 0) begin
          n.term = 1'b1;
          if (ar) n.cnt = m.reload;
          else begin
            n.cnt = 0; n.busy = 1'b0; n.done = 1'b1;
          end
        end else begin
          n.cnt = m.cnt - dec;
        end
      end
    end else if (m.done && ab) begin
      n.done = 1'b0;
    end else if (lv) begin
      n.reload = lval;
      if (lval == 0) begin
        n.done = 1'b1; n.term = 1'b1; n.cnt = 0;
      end else begin
        n.busy = 1'b1; n.done = 1'b0; n.cnt = lval;
      end
    end
    return n;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_a(bit r, bit lv, int v, bit e, bit ar, bit ab);
    rst_a = r; lif_a.loadValid = lv; lif_a.loadValue = WA'(v);
    en_a = e; ar_a = ar; ab_a = ab;
  endtask

  task automatic drive_b(bit r, bit lv, int v, bit e, bit ar, bit ab);
    rst_b = r; lif_b.loadValid = lv; lif_b.loadValue = WB'(v);
    en_b = e; ar_b = ar; ab_b = ab;
  endtask

  task automatic cycle();
    @(posedge clock);
    ma = mdl_step(ma, rst_a, lif_a.loadValid, int'(lif_a.loadValue), en_a, ar_a, ab_a, DA);
    mb = mdl_step(mb, rst_b, lif_b.loadValid, int'(lif_b.loadValue), en_b, ar_b, ab_b, DB);
    #1;
    chk("a_count",    32'(cnt_a),           32'(ma.cnt));
    chk("a_busy",     32'(busy_a),          32'(ma.busy));
    chk("a_done",     32'(done_a),          32'(ma.done));
    chk("a_terminal", 32'(term_a),          32'(ma.term));
    chk("a_ready",    32'(lif_a.loadReady), 32'(!ma.busy && !rst_a));
    chk("b_count",    32'(cnt_b),           32'(mb.cnt));
    chk("b_busy",     32'(busy_b),          32'(mb.busy));
    chk("b_done",     32'(done_b),          32'(mb.done));
    chk("b_terminal", 32'(term_b),          32'(mb.term));
    chk("b_ready",    32'(lif_b.loadReady), 32'(!mb.busy && !rst_b));
  endtask

  initial begin
    ma = '{cnt: 0, reload: 0, busy: 1'b0, done: 1'b0, term: 1'b0};
    mb = ma;

    drive_a(1, 0, 0, 0, 0, 0);
    drive_b(1, 0, 0, 0, 0, 0);
    repeat (2) cycle();
    drive_a(0, 0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0, 0);
    cycle();

    // Load 5, enable held, stop at terminal: 5,4,3,2,1,0 then DONE.
    drive_a(0, 1, 5, 1, 0, 0); cycle();
    drive_a(0, 0, 0, 1, 0, 0); repeat (7) cycle();

    // Step-3 instance: 7,4,1,0 with a single pulse.
    drive_b(0, 1, 7, 1, 0, 0); cycle();
    drive_b(0, 0, 0, 1, 0, 0); repeat (5) cycle();

    // Auto-reload of 3 for 12 enabled cycles, then abort out of RUNNING.
    drive_a(0, 1, 3, 1, 1, 0); cycle();
    drive_a(0, 0, 0, 1, 1, 0); repeat (12) cycle();
    drive_a(0, 0, 0, 1, 1, 1); cycle();
    drive_a(0, 0, 0, 0, 0, 0); cycle();

    // Enable alternating with load 4.
    drive_a(0, 1, 4, 0, 0, 0); cycle();
    for (int i = 0; i < 10; i++) begin
      drive_a(0, 0, 0, (i % 2) == 0, 0, 0); cycle();
    end

    // Zero load: immediate DONE with a terminal pulse, autoReload ignored.
    drive_a(0, 1, 0, 1, 1, 0); cycle();
    drive_a(0, 0, 0, 1, 0, 0); repeat (2) cycle();

    // Load 9, a load attempt while busy, then abort at count 5.
    drive_a(0, 1, 9, 1, 0, 0); cycle();
    drive_a(0, 0, 0, 1, 0, 0); repeat (2) cycle();
    drive_a(0, 1, 2, 1, 0, 0); cycle();
    drive_a(0, 0, 0, 1, 0, 0); cycle();
    drive_a(0, 0, 0, 1, 0, 1); cycle();
    drive_a(0, 0, 0, 1, 0, 0); repeat (2) cycle();

    // Same again, ended by reset instead of abort.
    drive_a(0, 1, 9, 1, 0, 0); cycle();
    drive_a(0, 0, 0, 1, 0, 0); repeat (4) cycle();
    drive_a(1, 0, 0, 1, 0, 0); cycle();
    drive_a(0, 0, 0, 1, 0, 0); repeat (2) cycle();

    // In DONE, abort beats a simultaneous load.
    drive_a(0, 1, 1, 1, 0, 0); cycle();
    drive_a(0, 0, 0, 1, 0, 0); cycle();
    drive_a(0, 1, 6, 1, 0, 1); cycle();
    drive_a(0, 0, 0, 1, 0, 0); repeat (2) cycle();

    // Back-to-back: new load in the first DONE cycle.
    drive_a(0, 1, 2, 1, 0, 0); cycle();
    drive_a(0, 0, 0, 1, 0, 0); repeat (2) cycle();
    drive_a(0, 1, 3, 1, 0, 0); cycle();
    drive_a(0, 0, 0, 1, 0, 0); repeat (4) cycle();

    // Randomized traffic on both instances.
    for (int i = 0; i < 600; i++) begin
      drive_a($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
              ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 12)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
      drive_b($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 15)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
